// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data memory responder; define DMEM_WBUF_EN for a one-entry write buffer
module dmem_responder #(
  parameter int         DEPTH_WORDS = 4096,
  parameter logic [3:0] REGION      = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_mem_req_i,
  input  logic        data_mem_wr_en_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [31:0] data_mem_data_i,
  output logic [31:0] data_mem_data_o,
  output logic        data_mem_rvalid_o,
  output logic        data_mem_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic IDLE = 1'b0;
  localparam logic RESP = 1'b1;

  logic [29:0]   word_a;
  logic [AW-1:0] idx;
  logic          in_range, rd_ok, wr_ok, bad;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata, rd_word;
  logic          state_q, state_d, rd_q, rd_d, err_q, err_d;
  logic [31:0]   data_q, data_d;

  // Word address drops the byte-lane bits; upper bits must match REGION and be zero above the array.
  assign word_a   = 30'(data_mem_addr_i >> 2);
  assign idx      = word_a[AW-1:0];
  assign in_range = (word_a[29:26] == REGION) && ((word_a[25:0] >> AW) == '0);
  assign rd_ok    = data_mem_req_i & ~data_mem_wr_en_i & in_range;
  assign wr_ok    = data_mem_req_i & data_mem_wr_en_i & in_range;
  assign bad      = data_mem_req_i & ~in_range;

`ifdef DMEM_WBUF_EN
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_idx_q, buf_idx_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          commit;

  // The buffer drains every cycle except when a write to its own word coalesces into it.
  always_comb begin
    commit     = buf_v_q & ~(wr_ok && idx == buf_idx_q);
    buf_v_d    = wr_ok;
    buf_idx_d  = wr_ok ? idx : buf_idx_q;
    buf_data_d = wr_ok ? data_mem_data_i : buf_data_q;
    mem_we     = commit;
    mem_widx   = buf_idx_q;
    mem_wdata  = buf_data_q;
    rd_word    = (buf_v_q && buf_idx_q == idx) ? buf_data_q : mem[idx];
  end

  // Reset drops a pending buffered write so the array keeps its prior value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q    <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
    end
  end
`else
  // Writes go straight to the array at the end of the request cycle.
  always_comb begin
    mem_we    = wr_ok;
    mem_widx  = idx;
    mem_wdata = data_mem_data_i;
    rd_word   = mem[idx];
  end
`endif

  // Array has no reset; contents survive reset and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Next response: out-of-range forces zero data, reads load the word, otherwise data holds.
  always_comb begin
    state_d = data_mem_req_i ? RESP : IDLE;
    rd_d    = rd_ok;
    err_d   = bad;
    data_d  = bad ? '0 : rd_ok ? rd_word : data_q;
  end

  // Response registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign data_mem_data_o   = data_q;
  assign data_mem_rvalid_o = (state_q == RESP) & rd_q;
  assign data_mem_err_o    = (state_q == RESP) & err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against an address-map model
module tb_dmem_responder;
  localparam int          DEPTH = 4096;
  localparam logic [3:0]  REG   = 4'h0;
  localparam longint      BASE  = longint'(REG) << 28;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, err;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [longint];
  logic [31:0] exp_data = '0;
  bit          known = 1'b1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .REGION(REG)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_mem_req_i(req), .data_mem_wr_en_i(wr),
    .data_mem_addr_i(addr), .data_mem_data_i(wdata),
    .data_mem_data_o(rdata), .data_mem_rvalid_o(rvalid), .data_mem_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    longint la;
    longint wi;
    bit inr;
    logic erv, eer;
    req = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    la  = longint'(a);
    inr = (la >= BASE) && (la < BASE + DEPTH * 4);
    wi  = (la - BASE) / 4;
    erv = 1'b0; eer = 1'b0;
    if (r && !inr) begin
      eer = 1'b1; exp_data = '0; known = 1'b1;
    end else if (r && w) begin
      model[wi] = d;
    end else if (r) begin
      erv = 1'b1;
      known = model.exists(wi);
      if (known) exp_data = model[wi];
    end
    check({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, erv});
    check({tag, ".err"}, {31'b0, err}, {31'b0, eer});
    if (known) check({tag, ".data"}, rdata, exp_data);
    req = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int w;
    #12;
    check("rst.data", rdata, 32'h0);
    check("rst.rvalid", {31'b0, rvalid}, 32'h0);
    check("rst.err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("w_dead", 1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    step("r_dead", 1, 0, 32'h0000_0013, 32'h0);
    step("w_1122", 1, 1, 32'h0000_0020, 32'h1122_3344);
    step("r_rmw", 1, 0, 32'h0000_0020, 32'h0);
    step("w_rmw", 1, 1, 32'h0000_0020, 32'h1122_33AA);
    step("idle0", 0, 0, 32'h0, 32'h0);
    step("r_rmw2", 1, 0, 32'h0000_0020, 32'h0);
    step("w_c1", 1, 1, 32'h0000_0040, 32'h1);
    step("w_c2", 1, 1, 32'h0000_0040, 32'h2);
    step("r_c", 1, 0, 32'h0000_0040, 32'h0);
    step("w_A", 1, 1, 32'h0000_0000, 32'hAAAA_0001);
    step("w_B", 1, 1, 32'h0000_0004, 32'hBBBB_0002);
    step("r_A", 1, 0, 32'h0000_0000, 32'h0);
    step("r_B", 1, 0, 32'h0000_0004, 32'h0);
    step("w_oor", 1, 1, 32'h1000_0000, 32'h5555_5555);
    step("r_oor", 1, 0, 32'h0000_4000, 32'h0);
    step("r_A2", 1, 0, 32'h0000_0000, 32'h0);
    step("w_top", 1, 1, 32'h0000_3FFC, 32'hC0FF_EE00);
    step("r_top", 1, 0, 32'h0000_3FFF, 32'h0);
    step("w_old8", 1, 1, 32'h0000_0008, 32'h0000_0077);
    step("idle1", 0, 0, 32'h0, 32'h0);
    step("w_new8", 1, 1, 32'h0000_0008, 32'h0000_0005);
    rst_n = 1'b0;
    #1;
    check("mid_rst.data", rdata, 32'h0);
    check("mid_rst.rvalid", {31'b0, rvalid}, 32'h0);
    check("mid_rst.err", {31'b0, err}, 32'h0);
`ifdef DMEM_WBUF_EN
    model[2] = 32'h0000_0077;
`endif
    exp_data = '0; known = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("in_rst.data", rdata, 32'h0);
    rst_n = 1'b1;
    step("r_8", 1, 0, 32'h0000_0008, 32'h0);
    for (int i = 0; i < 400; i++) begin
      w = int'($urandom_range(0, 31));
      a = 32'((w < 16 ? w : 4064 + w) * 4 + int'($urandom_range(0, 3)));
      case ($urandom_range(0, 9))
        0: a = 32'h0000_4000 + ($urandom & 32'h0FFF_FFFC);
        1: a = {4'h1 + 4'($urandom_range(0, 14)), 28'($urandom)};
        default: ;
      endcase
      step("rand", $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, a, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
